// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word, RAM status and memory-arbiter state types.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
   typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} arb_state_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter, data priority with a bounded data streak
// so a pending instruction fetch is never starved.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int MAX_DSTREAK = 4,
   parameter int ADDR_W = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [ADDR_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [ADDR_W-1:0] dstore,
   output logic              dwait,
   output logic [ADDR_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [ADDR_W-1:0] ramstore,
   input  logic [ADDR_W-1:0] ramload,
   input  ramstate_t         ramstate,
   output logic              proto_err
);
   localparam logic [3:0] MAX_S = 4'(MAX_DSTREAK);
   arb_state_t state, state_n;
   logic [3:0] dstreak, dstreak_n;
   logic d_req, d_done, i_done;
   assign d_req = dREN | dWEN;
   assign d_done = (state == GNT_D) && (ramstate == ACCESS);
   assign i_done = (state == GNT_I) && (ramstate == ACCESS);
   assign iwait = iREN & ~i_done;
   assign dwait = d_req & ~d_done;
   assign iload = ramload;
   assign dload = ramload;
   // enables track the live request so a dropped request aborts in the same cycle
   always_comb begin
      ramREN = (state == GNT_I) ? iREN : (state == GNT_D) ? (dREN & ~dWEN) : 1'b0;
      ramWEN = (state == GNT_D) & dWEN;
      ramaddr = (state == GNT_I) ? iaddr : (state == GNT_D) ? daddr : '0;
      ramstore = (state == GNT_D) ? dstore : '0;
   end
   always_comb begin
      state_n = state;
      dstreak_n = dstreak;
      case (state)
         IDLE:
            if (d_req && (!iREN || dstreak < MAX_S)) state_n = GNT_D;
            else if (iREN) state_n = GNT_I;
         GNT_D:
            if (!d_req) state_n = IDLE;
            else if (ramstate == ACCESS) begin
               state_n = IDLE;
               dstreak_n = !iREN ? 4'd0 : (dstreak == MAX_S) ? dstreak : dstreak + 4'd1;
            end
         GNT_I:
            if (!iREN) state_n = IDLE;
            else if (ramstate == ACCESS) begin
               state_n = IDLE;
               dstreak_n = 4'd0;
            end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state <= IDLE;
         dstreak <= 4'd0;
         proto_err <= 1'b0;
      end else begin
         state <= state_n;
         dstreak <= dstreak_n;
         proto_err <= proto_err | (dREN & dWEN);
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus hand sequences for starvation and abort.
module tb_mem_arbiter;
   import cpu_types_pkg::*;
   localparam logic [31:0] IA = 32'h40, DA = 32'h80, WA = 32'h100, WD = 32'hDEADBEEF;
   logic CLK, nRST, iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN, proto_err;
   logic [31:0] iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
   ramstate_t ramstate;
   int n_cmp = 0, n_bad = 0;
   typedef struct {
      bit chk, nrst, iren, dren, dwen;
      ramstate_t rs;
      logic [31:0] ia, da, ds, ld;
      bit iw, dw, ren, wen, pe;
      logic [31:0] ra, rsto;
   } vec_t;
   vec_t v [15];
   mem_arbiter #(.MAX_DSTREAK(4), .ADDR_W(32)) dut (
      .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .proto_err(proto_err)
   );
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask
   initial begin
      bit exp_g [6];
      bit got_g [6];
      int ng;
      v[0]  = '{0,0,1,0,0,FREE,  IA,0, 0, 0,            1,0,0,0,0, 0, 0};
      v[1]  = '{1,0,1,0,0,FREE,  IA,0, 0, 0,            1,0,0,0,0, 0, 0};
      v[2]  = '{1,1,1,0,0,FREE,  IA,0, 0, 0,            1,0,0,0,0, 0, 0};
      v[3]  = '{1,1,1,0,0,BUSY,  IA,0, 0, 0,            1,0,1,0,0, IA,0};
      v[4]  = '{1,1,1,0,0,BUSY,  IA,0, 0, 0,            1,0,1,0,0, IA,0};
      v[5]  = '{1,1,1,0,0,ACCESS,IA,0, 0, 32'h2001000A, 0,0,1,0,0, IA,0};
      v[6]  = '{1,1,0,0,0,FREE,  IA,0, 0, 0,            0,0,0,0,0, 0, 0};
      v[7]  = '{1,1,1,1,0,FREE,  IA,DA,0, 0,            1,1,0,0,0, 0, 0};
      v[8]  = '{1,1,1,1,0,ACCESS,IA,DA,0, 32'h11,       1,0,1,0,0, DA,0};
      v[9]  = '{1,1,1,0,0,FREE,  IA,DA,0, 0,            1,0,0,0,0, 0, 0};
      v[10] = '{1,1,1,0,0,ACCESS,IA,DA,0, 32'h22,       0,0,1,0,0, IA,0};
      v[11] = '{1,1,0,1,1,FREE,  IA,WA,WD,0,            0,1,0,0,0, 0, 0};
      v[12] = '{1,1,0,1,1,BUSY,  IA,WA,WD,0,            0,1,0,1,1, WA,WD};
      v[13] = '{1,1,0,1,1,ACCESS,IA,WA,WD,32'h33,       0,0,0,1,1, WA,WD};
      v[14] = '{1,1,0,0,0,FREE,  IA,WA,WD,0,            0,0,0,0,1, 0, 0};
      for (int i = 0; i < 15; i++) begin
         @(negedge CLK);
         nRST = v[i].nrst; iREN = v[i].iren; dREN = v[i].dren; dWEN = v[i].dwen;
         ramstate = v[i].rs; iaddr = v[i].ia; daddr = v[i].da; dstore = v[i].ds; ramload = v[i].ld;
         #1;
         if (v[i].chk) begin
            check($sformatf("v%0d iwait", i), 32'(iwait), 32'(v[i].iw));
            check($sformatf("v%0d dwait", i), 32'(dwait), 32'(v[i].dw));
            check($sformatf("v%0d ramREN", i), 32'(ramREN), 32'(v[i].ren));
            check($sformatf("v%0d ramWEN", i), 32'(ramWEN), 32'(v[i].wen));
            check($sformatf("v%0d proto_err", i), 32'(proto_err), 32'(v[i].pe));
            check($sformatf("v%0d ramaddr", i), ramaddr, v[i].ra);
            check($sformatf("v%0d ramstore", i), ramstore, v[i].rsto);
            if (v[i].iren && !v[i].iw) check($sformatf("v%0d iload", i), iload, v[i].ld);
            if ((v[i].dren || v[i].dwen) && !v[i].dw) check($sformatf("v%0d dload", i), dload, v[i].ld);
         end
      end
      // starvation: iREN and dREN held with instant ACCESS -> D D D D I D
      exp_g = '{1, 1, 1, 1, 0, 1};
      @(negedge CLK);
      nRST = 0; iREN = 1; dREN = 1; dWEN = 0; ramstate = ACCESS; iaddr = IA; daddr = DA; ramload = 0;
      @(negedge CLK);
      nRST = 1;
      ng = 0;
      for (int c = 0; c < 40 && ng < 6; c++) begin
         #1;
         if (ramREN) begin
            got_g[ng] = (ramaddr == DA);
            ng++;
         end
         @(negedge CLK);
      end
      check("starve grant count", 32'(ng), 32'd6);
      for (int k = 0; k < ng; k++) check($sformatf("starve grant%0d is_data", k), 32'(got_g[k]), 32'(exp_g[k]));
      // error retry then abort
      nRST = 0; iREN = 0; dREN = 0; ramstate = FREE;
      @(negedge CLK);
      nRST = 1; dREN = 1;
      @(negedge CLK);
      ramstate = ERROR;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("err%0d dwait", c), 32'(dwait), 32'd1);
         check($sformatf("err%0d ramREN", c), 32'(ramREN), 32'd1);
         @(negedge CLK);
      end
      dREN = 0;
      #1;
      check("abort ramREN", 32'(ramREN), 32'd0);
      check("abort dwait", 32'(dwait), 32'd0);
      @(negedge CLK);
      dREN = 1; ramstate = ACCESS;
      #1;
      check("post-abort idle ramREN", 32'(ramREN), 32'd0);
      check("post-abort idle dwait", 32'(dwait), 32'd1);
      @(negedge CLK);
      #1;
      check("regrant ramREN", 32'(ramREN), 32'd1);
      check("regrant ramaddr", ramaddr, DA);
      check("regrant dwait", 32'(dwait), 32'd0);
      check("no proto_err", 32'(proto_err), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
